fifo_spi_dac_tx: RTL and testbench

- Read-side consumer for the 16-bit synchronous sample FIFO (depth 15).
- Pops one word at a time via read_en/empty and serialises each word MSB-first to an SPI DAC. Uses SPI mode 0 and one chip-select frame per word.
- Sits between the sample FIFO's read port and the DAC pins on the analog card.

---
 rtl/fifo_spi_dac_tx.sv | 181 ++++++++++++++++++
 tb/tb_fifo_spi_dac_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_spi_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_spi_dac_tx
// Description : Pops 16-bit samples from the synchronous sample FIFO one at
//               a time and shifts each one MSB-first to an SPI DAC (mode 0,
//               one chip-select frame per word).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_spi_dac_tx #(
    parameter int CLK_DIV = 2,   // clk cycles per SCLK half-period (1..255)
    parameter int CS_GAP  = 2,   // clk cycles CS stays high between frames (1..255)
    parameter int DATA_W  = 16   // bits per frame, equals the FIFO word width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rd_en_o,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_cnt_o
);

    // Out-of-range parameters stop elaboration.
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_chk_clk_div
        $error("fifo_spi_dac_tx: CLK_DIV must be in 1..255");
    end
    if (CS_GAP < 1 || CS_GAP > 255) begin : g_chk_cs_gap
        $error("fifo_spi_dac_tx: CS_GAP must be in 1..255");
    end
    if (DATA_W < 2) begin : g_chk_data_w
        $error("fifo_spi_dac_tx: DATA_W must be at least 2");
    end

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [7:0]       c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]       c_GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] c_BIT_TOP  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          div_q, div_d;        // half-period divider
    logic [7:0]          gap_q, gap_d;        // inter-frame CS-high counter
    logic [BIT_W-1:0]    bit_q, bit_d;        // bits left in the frame, counting down
    logic [DATA_W-1:0]   shreg_q, shreg_d;    // word being shifted, MSB aligned
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                rd_en_q, rd_en_d;
    logic                done_q, done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            gap_q       <= 8'd0;
            bit_q       <= '0;
            shreg_q     <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            rd_en_q     <= rd_en_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic: pop, load, shift DATA_W bits in mode 0, then CS gap.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        gap_d       = gap_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        rd_en_d     = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Empty is only looked at here, so a strobe never hits an empty FIFO.
                if (enable && !fifo_empty_i) begin
                    rd_en_d = 1'b1;
                    state_d = S_POP;
                end
            end

            S_POP: begin
                // FIFO pops at this edge; its data output is valid during LOAD.
                state_d = S_LOAD;
            end

            S_LOAD: begin
                shreg_d = fifo_data_i;
                cs_n_d  = 1'b0;
                mosi_d  = fifo_data_i[DATA_W-1];
                sclk_d  = 1'b0;
                div_d   = 8'd0;
                bit_d   = c_BIT_TOP;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                if (div_q == c_DIV_LAST) begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        // End of low phase: rising edge, DAC samples MOSI.
                        sclk_d = 1'b1;
                    end else begin
                        // End of high phase: falling edge, MOSI may change.
                        sclk_d = 1'b0;
                        if (bit_q == '0) begin
                            cs_n_d      = 1'b1;
                            mosi_d      = 1'b0;
                            done_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            gap_d       = 8'd0;
                            state_d     = S_GAP;
                        end else begin
                            bit_d   = bit_q - 1'b1;
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[DATA_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            S_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fifo_rd_en_o = rd_en_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_spi_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_spi_dac_tx
// Description : Bench for fifo_spi_dac_tx with a behavioural FIFO and an
//               SPI pin monitor that rebuilds each frame from SCLK rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_spi_dac_tx;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int DATA_W  = 16;
    localparam int LOW_LEN = 2 * CLK_DIV * DATA_W;
    localparam int PERIOD  = LOW_LEN + CS_GAP + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_data = 16'd0;
    logic        fifo_rd_en;
    logic        spi_sclk, spi_mosi, spi_cs_n, busy, frame_done;
    logic [15:0] frame_cnt;

    fifo_spi_dac_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_en_o (fifo_rd_en),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .frame_cnt_o  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural sample FIFO: data registered one cycle after the strobe.
    logic [15:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state and pin monitor bookkeeping.
    logic [15:0] exp_q [$];
    logic [15:0] inflight = 16'd0;
    logic [15:0] cur_word = 16'd0;
    logic [15:0] model_cnt = 16'd0;
    bit          aborting = 1'b0;
    int          cyc = 0;
    logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_rd = 1'b0, p_done = 1'b0;
    int          n_rd = 0, n_frames = 0, n_done = 0;
    int          v_rd_empty = 0, v_rd_wide = 0, v_mosi = 0, v_sclk = 0, v_done = 0, v_busy = 0, v_extra = 0;
    int          last_rd_rise = 0, last_cs_fall = 0, first_rise = 0, nbits = 0;
    int          last_low = 0, last_nbits = 0;
    int          starts [$];

    // One clock: sample just after the edge and update the model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_rd_en && fifo_empty) v_rd_empty++;
        if (fifo_rd_en && !p_rd) begin n_rd++; last_rd_rise = cyc; end
        if (fifo_rd_en && p_rd) v_rd_wide++;
        if (spi_cs_n && spi_sclk) v_sclk++;
        if (!spi_cs_n && !busy) v_busy++;
        if ((spi_mosi !== p_mosi) && !(p_sclk && !spi_sclk) && (spi_cs_n == p_cs)) v_mosi++;
        if (!spi_cs_n && p_cs) begin
            last_cs_fall = cyc;
            starts.push_back(cyc);
            nbits    = 0;
            cur_word = 16'd0;
            if (exp_q.size() == 0) v_extra++;
            else inflight = exp_q.pop_front();
        end
        if (spi_sclk && !p_sclk && !spi_cs_n) begin
            if (nbits == 0) first_rise = cyc;
            cur_word = {cur_word[14:0], spi_mosi};
            nbits++;
        end
        if (spi_cs_n && !p_cs) begin
            if (aborting) begin
                aborting = 1'b0;
            end else begin
                n_frames++;
                model_cnt  = model_cnt + 16'd1;
                last_low   = cyc - last_cs_fall;
                last_nbits = nbits;
                check("frame_word", cur_word, inflight);
                check("frame_cnt", frame_cnt, model_cnt);
                if (!frame_done) v_done++;
            end
        end
        if (frame_done && !p_done) n_done++;
        if (frame_done && p_done) v_done++;
        if (frame_done && !(spi_cs_n && !p_cs)) v_done++;
        p_sclk = spi_sclk; p_cs = spi_cs_n; p_mosi = spi_mosi;
        p_rd = fifo_rd_en; p_done = frame_done;
    endtask

    task automatic push(input logic [15:0] w);
        int k = 0;
        while ((wr_ptr - rd_ptr) >= 15 && k < 2000) begin
            enable = 1'b1;
            tick();
            k++;
        end
        if (k >= 2000) check("push_timeout", wr_ptr - rd_ptr, 14);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int k = 0;
        while (n_frames < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, n_frames, target);
    endtask

    task automatic wait_bits(input string tag, input int nb);
        int k = 0;
        while (!(!spi_cs_n && nbits == nb) && k < 400) begin
            tick();
            k++;
        end
        check(tag, nbits, nb);
    endtask

    initial begin
        int base_rd, base_fr, base_done, s0, nbad, rst_cyc;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        check("reset_outs", {fifo_rd_en, spi_sclk, spi_mosi, spi_cs_n, busy, frame_done}, 6'b000100);
        check("reset_cnt", frame_cnt, 16'h0000);
        rst = 1'b0;
        tick();

        // Single word 0xA5C3: latency, bit pattern, CS width.
        base_rd = n_rd; base_done = n_done;
        push(16'hA5C3);
        enable = 1'b1;
        wait_frames("t1_timeout", 1, 300);
        repeat (5) tick();
        check("t1_rd_pulses", n_rd - base_rd, 1);
        check("t1_cs_latency", last_cs_fall - last_rd_rise, 2);
        check("t1_sclk_latency", first_rise - last_cs_fall, CLK_DIV);
        check("t1_cs_low", last_low, LOW_LEN);
        check("t1_bits", last_nbits, DATA_W);
        check("t1_done_pulses", n_done - base_done, 1);
        check("t1_cnt", frame_cnt, 16'd1);

        // 15 queued words back to back.
        enable = 1'b0;
        repeat (10) tick();
        for (int i = 1; i <= 15; i++) push(16'(i));
        base_rd = n_rd; base_fr = n_frames; s0 = starts.size();
        enable = 1'b1;
        wait_frames("t2_timeout", base_fr + 15, 15 * PERIOD + 200);
        check("t2_rd_pulses", n_rd - base_rd, 15);
        nbad = 0;
        for (int i = s0 + 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != PERIOD) nbad++;
        check("t2_spacing_bad", nbad, 0);
        check("t2_fifo_left", wr_ptr - rd_ptr, 0);

        // Enabled but empty: nothing moves.
        repeat (10) tick();
        nbad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fifo_rd_en || !spi_cs_n || busy) nbad++;
        end
        check("t3_idle_bad", nbad, 0);

        // Drop enable after the 5th SCLK rise with 3 words queued.
        push(16'($urandom)); push(16'($urandom)); push(16'($urandom));
        wait_bits("t4_reach_bit5", 5);
        enable = 1'b0;
        base_rd = n_rd; base_fr = n_frames;
        repeat (300) tick();
        check("t4_frames", n_frames - base_fr, 1);
        check("t4_bits", last_nbits, DATA_W);
        check("t4_rd_pulses", n_rd - base_rd, 0);
        check("t4_fifo_left", wr_ptr - rd_ptr, 2);

        // Reset mid-frame at bit 8, then restart.
        enable = 1'b1;
        wait_bits("t5_reach_bit8", 8);
        aborting = 1'b1;
        rst = 1'b1;
        tick();
        model_cnt = 16'd0;
        check("t5_rst_outs", {fifo_rd_en, spi_sclk, spi_mosi, spi_cs_n, busy, frame_done}, 6'b000100);
        check("t5_rst_cnt", frame_cnt, 16'h0000);
        rst = 1'b0;
        rst_cyc = cyc;
        base_fr = n_frames;
        wait_frames("t5_timeout", base_fr + 1, PERIOD + 50);
        check("t5_restart", last_cs_fall - rst_cyc, 3);
        check("t5_fifo_left", wr_ptr - rd_ptr, 0);

        // Frame counter wrap: preset near 0xFFFF, then two frames.
        enable = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        tick();
        @(negedge clk);
        release dut.frame_cnt_q;
        model_cnt = 16'hFFFE;
        tick();
        push(16'h1234); push(16'hEDCB);
        enable = 1'b1;
        base_fr = n_frames;
        wait_frames("t6_timeout", base_fr + 2, 2 * PERIOD + 50);
        check("t6_wrap", frame_cnt, 16'h0000);

        // Random words with random enable toggling and idle gaps.
        base_fr = n_frames;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            push(16'($urandom));
            repeat ($urandom_range(0, 80)) tick();
        end
        enable = 1'b1;
        wait_frames("t7_timeout", base_fr + 24, 24 * PERIOD + 2000);
        check("t7_fifo_left", wr_ptr - rd_ptr, 0);

        repeat (10) tick();
        check("rd_while_empty", v_rd_empty, 0);
        check("rd_pulse_width", v_rd_wide, 0);
        check("mosi_change", v_mosi, 0);
        check("sclk_idle", v_sclk, 0);
        check("done_pulse", v_done, 0);
        check("busy_in_frame", v_busy, 0);
        check("extra_frame", v_extra, 0);
        check("done_count", n_done, n_frames);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
